// File: rtl/alarm_unit.sv
// Alarm stage for the 12-hour BCD clock: settable alarm time, ring/snooze/stop FSM, buzzer tone.
// Optional macro ALARM_BEEP_GATE_EN gates the tone with a 1 s on / 1 s off phase while ringing.
module alarm_unit #(
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int BEEP_DIV   = 12500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic [6:0] cur_sec,
    input  logic [6:0] cur_min,
    input  logic [4:0] cur_hr,
    input  logic       cur_pm,
    input  logic       alarm_en,
    input  logic       set_btn,
    input  logic       inc_btn,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic [4:0] alm_hr,
    output logic [6:0] alm_min,
    output logic       alm_pm,
    output logic [1:0] setting,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzzer
);

    localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
    localparam int DW = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(BEEP_DIV - 1);
    localparam logic [15:0]   SNZ_LOAD  = 16'(SNOOZE_MIN * 60);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET_HR  = 3'd1,
        ST_SET_MIN = 3'd2,
        ST_RING    = 3'd3,
        ST_SNOOZE  = 3'd4
    } state_t;

    state_t        state_r, next_state_s;
    logic [4:0]    alm_hr_r;
    logic [6:0]    alm_min_r;
    logic          alm_pm_r;
    logic [1:0]    setting_r, setting_nxt_s;
    logic          ringing_r, ringing_nxt_s;
    logic          snoozing_r, snoozing_nxt_s;
    logic          buzzer_r, buzzer_nxt_s;
    logic          tone_r, tone_nxt_s;
    logic [DW-1:0] div_r, div_nxt_s;
    logic [RW-1:0] ring_cnt_r;
    logic [15:0]   snz_cnt_r;
    logic          match_now_s, match_q_r, trigger_s;
`ifdef ALARM_BEEP_GATE_EN
    logic          phase_r, phase_nxt_s;
`endif

    // BCD hour step 01..12, 12 wraps to 01
    function automatic logic [4:0] hr_step(input logic [4:0] hr);
        logic [4:0] r;
        if (hr == 5'h12) begin
            r = 5'h01;
        end else if (hr[3:0] == 4'h9) begin
            r = 5'h10;
        end else begin
            r = hr + 5'd1;
        end
        return r;
    endfunction

    // BCD minute step 00..59, 59 wraps to 00 without carry
    function automatic logic [6:0] min_step(input logic [6:0] mn);
        logic [6:0] r;
        if (mn == 7'h59) begin
            r = 7'h00;
        end else if (mn[3:0] == 4'h9) begin
            r = {mn[6:4] + 3'd1, 4'h0};
        end else begin
            r = mn + 7'd1;
        end
        return r;
    endfunction

    assign match_now_s = alarm_en && (cur_hr == alm_hr_r) && (cur_min == alm_min_r) &&
                         (cur_pm == alm_pm_r) && (cur_sec == 7'h00);
    assign trigger_s   = match_now_s && !match_q_r;

    // State register and match edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            match_q_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            match_q_r <= match_now_s;
        end
    end

    // Next-state logic; alarm_en drop outranks stop, which outranks snooze
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    next_state_s = ST_RING;
                end else if (set_btn) begin
                    next_state_s = ST_SET_HR;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SET_HR: begin
                if (set_btn) next_state_s = ST_SET_MIN;
                else         next_state_s = ST_SET_HR;
            end
            ST_SET_MIN: begin
                if (set_btn) next_state_s = ST_IDLE;
                else         next_state_s = ST_SET_MIN;
            end
            ST_RING: begin
                if (!alarm_en || stop_btn) begin
                    next_state_s = ST_IDLE;
                end else if (snooze_btn) begin
                    next_state_s = ST_SNOOZE;
                end else if (sec_tick && (ring_cnt_r == RING_LAST)) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RING;
                end
            end
            ST_SNOOZE: begin
                if (!alarm_en || stop_btn) begin
                    next_state_s = ST_IDLE;
                end else if (sec_tick && (snz_cnt_r == 16'd1)) begin
                    next_state_s = ST_RING;
                end else begin
                    next_state_s = ST_SNOOZE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the status flags are registered
    always_comb begin
        setting_nxt_s  = 2'b00;
        ringing_nxt_s  = 1'b0;
        snoozing_nxt_s = 1'b0;
        case (next_state_s)
            ST_SET_HR:  setting_nxt_s  = 2'b01;
            ST_SET_MIN: setting_nxt_s  = 2'b10;
            ST_RING:    ringing_nxt_s  = 1'b1;
            ST_SNOOZE:  snoozing_nxt_s = 1'b1;
            default:    setting_nxt_s  = 2'b00;
        endcase
    end

    // Tone divider; a fresh RING entry restarts with tone low
    always_comb begin
        div_nxt_s  = '0;
        tone_nxt_s = 1'b0;
        if ((state_r == ST_RING) && (next_state_s == ST_RING)) begin
            if (div_r == DIV_LAST) begin
                div_nxt_s  = '0;
                tone_nxt_s = ~tone_r;
            end else begin
                div_nxt_s  = div_r + {{(DW-1){1'b0}}, 1'b1};
                tone_nxt_s = tone_r;
            end
        end else begin
            div_nxt_s  = '0;
            tone_nxt_s = 1'b0;
        end
    end

`ifdef ALARM_BEEP_GATE_EN
    // Beep phase flips each second while ringing and re-arms high on entry
    always_comb begin
        phase_nxt_s = 1'b1;
        if ((state_r == ST_RING) && (next_state_s == ST_RING)) begin
            phase_nxt_s = sec_tick ? ~phase_r : phase_r;
        end else begin
            phase_nxt_s = 1'b1;
        end
        buzzer_nxt_s = tone_nxt_s & phase_nxt_s;
    end
`else
    assign buzzer_nxt_s = tone_nxt_s;
`endif

    // Registered status outputs and tone state
    always_ff @(posedge clk) begin
        if (rst) begin
            setting_r  <= 2'b00;
            ringing_r  <= 1'b0;
            snoozing_r <= 1'b0;
            buzzer_r   <= 1'b0;
            tone_r     <= 1'b0;
            div_r      <= '0;
`ifdef ALARM_BEEP_GATE_EN
            phase_r    <= 1'b1;
`endif
        end else begin
            setting_r  <= setting_nxt_s;
            ringing_r  <= ringing_nxt_s;
            snoozing_r <= snoozing_nxt_s;
            buzzer_r   <= buzzer_nxt_s;
            tone_r     <= tone_nxt_s;
            div_r      <= div_nxt_s;
`ifdef ALARM_BEEP_GATE_EN
            phase_r    <= phase_nxt_s;
`endif
        end
    end

    // Ring-seconds and snooze-seconds counters
    always_ff @(posedge clk) begin
        if (rst) begin
            ring_cnt_r <= '0;
            snz_cnt_r  <= 16'd0;
        end else begin
            if ((next_state_s == ST_RING) && (state_r != ST_RING)) begin
                ring_cnt_r <= '0;
            end else if ((state_r == ST_RING) && sec_tick) begin
                ring_cnt_r <= ring_cnt_r + {{(RW-1){1'b0}}, 1'b1};
            end else begin
                ring_cnt_r <= ring_cnt_r;
            end
            if ((state_r == ST_RING) && (next_state_s == ST_SNOOZE)) begin
                snz_cnt_r <= SNZ_LOAD;
            end else if ((state_r == ST_SNOOZE) && sec_tick && (snz_cnt_r != 16'd0)) begin
                snz_cnt_r <= snz_cnt_r - 16'd1;
            end else begin
                snz_cnt_r <= snz_cnt_r;
            end
        end
    end

    // Alarm time registers; 11 -> 12 flips AM/PM
    always_ff @(posedge clk) begin
        if (rst) begin
            alm_hr_r  <= 5'h12;
            alm_min_r <= 7'h00;
            alm_pm_r  <= 1'b0;
        end else if ((state_r == ST_SET_HR) && inc_btn) begin
            alm_hr_r  <= hr_step(alm_hr_r);
            alm_pm_r  <= (alm_hr_r == 5'h11) ? ~alm_pm_r : alm_pm_r;
        end else if ((state_r == ST_SET_MIN) && inc_btn) begin
            alm_min_r <= min_step(alm_min_r);
        end else begin
            alm_hr_r  <= alm_hr_r;
            alm_min_r <= alm_min_r;
            alm_pm_r  <= alm_pm_r;
        end
    end

    assign alm_hr   = alm_hr_r;
    assign alm_min  = alm_min_r;
    assign alm_pm   = alm_pm_r;
    assign setting  = setting_r;
    assign ringing  = ringing_r;
    assign snoozing = snoozing_r;
    assign buzzer   = buzzer_r;

endmodule

// File: tb/tb_alarm_unit.sv
// Directed scoreboard bench for alarm_unit (RING_SECS=60, SNOOZE_MIN=5, BEEP_DIV=4).
module tb_alarm_unit;

    logic       clk = 1'b0;
    logic       rst, sec_tick, cur_pm, alarm_en;
    logic       set_btn, inc_btn, snooze_btn, stop_btn;
    logic [6:0] cur_sec, cur_min;
    logic [4:0] cur_hr;
    logic [4:0] alm_hr;
    logic [6:0] alm_min;
    logic       alm_pm;
    logic [1:0] setting;
    logic       ringing, snoozing, buzzer;

    always #5 clk = ~clk;

    alarm_unit #(.RING_SECS(60), .SNOOZE_MIN(5), .BEEP_DIV(4)) dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick),
        .cur_sec(cur_sec), .cur_min(cur_min), .cur_hr(cur_hr), .cur_pm(cur_pm),
        .alarm_en(alarm_en), .set_btn(set_btn), .inc_btn(inc_btn),
        .snooze_btn(snooze_btn), .stop_btn(stop_btn),
        .alm_hr(alm_hr), .alm_min(alm_min), .alm_pm(alm_pm), .setting(setting),
        .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
    );

    localparam logic [17:0] M_ALL   = 18'h3FFFF;
    localparam logic [17:0] M_NOBUZ = 18'h3FFFE;

    typedef struct {
        string       tag;
        logic [17:0] mask;
        logic [17:0] exp;
    } sb_t;

    sb_t  sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model of the alarm registers and status flags, in plain integers
    int         m_hr, m_min;
    logic       m_pm, m_ring, m_snz, m_buz;
    logic [1:0] m_set;

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic logic [17:0] pk();
        logic [7:0] h;
        logic [7:0] m;
        h = bcd(m_hr);
        m = bcd(m_min);
        return {h[4:0], m[6:0], m_pm, m_set, m_ring, m_snz, m_buz};
    endfunction

    task automatic model_reset();
        m_hr = 12; m_min = 0; m_pm = 1'b0; m_set = 2'b00;
        m_ring = 1'b0; m_snz = 1'b0; m_buz = 1'b0;
    endtask

    task automatic model_hr_inc();
        m_hr = (m_hr == 12) ? 1 : m_hr + 1;
        if (m_hr == 12) m_pm = ~m_pm;
    endtask

    task automatic check_front();
        sb_t        e;
        logic [17:0] obs;
        obs = {alm_hr, alm_min, alm_pm, setting, ringing, snoozing, buzzer};
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard_empty observed=%h expected=entry", obs);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            assert ((obs & e.mask) === (e.exp & e.mask)) else begin
                n_bad++;
                $error("FAIL %s observed=%h expected=%h mask=%h", e.tag, obs, e.exp, e.mask);
            end
        end
    endtask

    // Push the model's expectation, clock one edge, drop pulses, compare
    task automatic run(input string tag, input logic [17:0] mask);
        sb.push_back('{tag, mask, pk()});
        @(posedge clk);
        #1;
        set_btn = 1'b0; inc_btn = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0; sec_tick = 1'b0;
        check_front();
    endtask

    initial begin
        rst = 1'b1; sec_tick = 1'b0; alarm_en = 1'b0;
        set_btn = 1'b0; inc_btn = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
        cur_hr = 5'h01; cur_min = 7'h00; cur_sec = 7'h00; cur_pm = 1'b0;
        model_reset();
        run("reset", M_ALL);
        rst = 1'b0;
        run("reset_release", M_ALL);

        // Walk the set modes without incrementing
        set_btn = 1'b1; m_set = 2'b01; run("set_hr_enter", M_ALL);
        set_btn = 1'b1; m_set = 2'b10; run("set_min_enter", M_ALL);
        set_btn = 1'b1; m_set = 2'b00; run("set_exit", M_ALL);
        run("idle_hold", M_ALL);

        // Hour stepping through 11 -> 12 (PM flip) and 12 -> 01
        set_btn = 1'b1; m_set = 2'b01; run("set_hr_enter2", M_ALL);
        for (int i = 0; i < 13; i++) begin
            inc_btn = 1'b1; model_hr_inc(); run("hr_inc", M_ALL);
        end
        set_btn = 1'b1; m_set = 2'b10; run("set_min_enter2", M_ALL);
        for (int i = 0; i < 61; i++) begin
            inc_btn = 1'b1; m_min = (m_min + 1) % 60; run("min_inc", M_ALL);
        end
        set_btn = 1'b1; m_set = 2'b00; run("set_exit2", M_ALL);

        // Program 06:30 AM
        set_btn = 1'b1; m_set = 2'b01; run("set_hr_enter3", M_ALL);
        while (!((m_hr == 6) && (m_pm == 1'b0))) begin
            inc_btn = 1'b1; model_hr_inc(); run("hr_to_6am", M_ALL);
        end
        set_btn = 1'b1; m_set = 2'b10; run("set_min_enter3", M_ALL);
        while (m_min != 30) begin
            inc_btn = 1'b1; m_min = m_min + 1; run("min_to_30", M_ALL);
        end
        set_btn = 1'b1; m_set = 2'b00; run("set_exit3", M_ALL);

        // Match and one-cycle ring latency
        alarm_en = 1'b1; cur_hr = 5'h06; cur_min = 7'h29; cur_sec = 7'h59; cur_pm = 1'b0;
        run("pre_match", M_ALL);
        cur_min = 7'h30; cur_sec = 7'h00;
        m_ring = 1'b1; m_buz = 1'b0;
        run("ring_latency", M_ALL);
        for (int k = 1; k <= 12; k++) begin
            m_buz = ((k / 4) % 2) == 1;
            run("beep_div4", M_ALL);
        end
        for (int i = 1; i <= 60; i++) begin
            sec_tick = 1'b1;
            if (i == 60) begin
                m_ring = 1'b0; m_buz = 1'b0;
            end
            run("ring_timeout", (i == 60) ? M_ALL : M_NOBUZ);
        end
        repeat (4) run("no_retrigger", M_ALL);

        // Snooze for 300 s, then stop beats snooze
        cur_sec = 7'h01; run("match_drop", M_ALL);
        cur_sec = 7'h00; m_ring = 1'b1; m_buz = 1'b0; run("retrigger", M_ALL);
        snooze_btn = 1'b1; m_ring = 1'b0; m_snz = 1'b1; run("snooze_enter", M_ALL);
        for (int i = 1; i <= 300; i++) begin
            sec_tick = 1'b1;
            if (i == 300) begin
                m_ring = 1'b1; m_snz = 1'b0; m_buz = 1'b0;
            end
            run("snooze_count", M_ALL);
        end
        stop_btn = 1'b1; snooze_btn = 1'b1; m_ring = 1'b0; run("stop_over_snooze", M_ALL);

        // alarm_en drop, re-arm edge, and reset mid-ring
        cur_sec = 7'h01; run("match_drop2", M_ALL);
        cur_sec = 7'h00; m_ring = 1'b1; m_buz = 1'b0; run("ring2", M_ALL);
        for (int k = 1; k <= 5; k++) begin
            m_buz = ((k / 4) % 2) == 1;
            run("beep2", M_ALL);
        end
        alarm_en = 1'b0; m_ring = 1'b0; m_buz = 1'b0; run("en_drop", M_ALL);
        alarm_en = 1'b1; m_ring = 1'b1; run("en_rearm_trigger", M_ALL);
        run("ringing_hold", M_ALL);
        rst = 1'b1; model_reset(); run("rst_mid_ring", M_ALL);
        rst = 1'b0; run("post_rst_idle", M_ALL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
